// File: rtl/my_fir_pkg.sv
// Shared types and sizing helpers for the time-multiplexed FIR filter.
package my_fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MAC   = 2'd2,
        DONE  = 2'd3
    } fir_state_e;

    localparam int DEF_INPUT_WIDTH  = 16;
    localparam int DEF_OUTPUT_WIDTH = 38;
    localparam int DEF_FIR_SIZE     = 64;

    // Smallest accumulator width that cannot overflow for the given sample width and tap count.
    function automatic int min_output_width(input int in_w, input int taps);
        return 2 * in_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/my_fir_if.sv
// Sample-in / result-out signal bundle between the sample source, the FIR and the consumer.
interface my_fir_if #(
    parameter int InputWidth  = 16,
    parameter int OutputWidth = 38
);
    // inputValid is a one-cycle strobe qualifying FIR_input; there is no ready, so a strobe
    // arriving while the filter is busy is dropped. outputValid is a one-cycle strobe
    // qualifying FIR_output, which then holds until the next result.
    logic                          inputValid;
    logic signed [InputWidth-1:0]  FIR_input;
    logic                          outputValid;
    logic signed [OutputWidth-1:0] FIR_output;

    modport master (
        output inputValid,
        output FIR_input,
        input  outputValid,
        input  FIR_output
    );

    modport slave (
        input  inputValid,
        input  FIR_input,
        output outputValid,
        output FIR_output
    );
endinterface

// File: rtl/my_fir_coeff_rom.sv
// Read-only coefficient store with a registered read port; c[0] sits in the low bits of INIT.
module my_fir_coeff_rom #(
    parameter int                     DEPTH  = 64,
    parameter int                     WIDTH  = 16,
    parameter int                     ADDR_W = 6,
    parameter logic [DEPTH*WIDTH-1:0] INIT   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       addr_i,
    output logic signed [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0]        rom [DEPTH];
    logic signed [WIDTH-1:0] data_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = INIT[k*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= rom[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/my_fir.sv
// Direct-form FIR: each accepted sample shifts the delay line, then one MAC per clock
// over all taps, and the sum is presented with a one-cycle outputValid strobe.
module my_fir
    import my_fir_pkg::*;
#(
    parameter int                               InputWidth  = DEF_INPUT_WIDTH,
    parameter int                               OutputWidth = DEF_OUTPUT_WIDTH,
    parameter int                               FIR_size    = DEF_FIR_SIZE,
    parameter logic [FIR_size*InputWidth-1:0]   COEFF_INIT  = '0
) (
    input  logic       clk,
    input  logic       rst,
    my_fir_if.slave    bus,
    output fir_state_e state_o
);

    localparam int               IDX_W    = (FIR_size > 1) ? $clog2(FIR_size) : 1;
    localparam int               PROD_W   = 2 * InputWidth;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIR_size - 1);

    if (OutputWidth < min_output_width(InputWidth, FIR_size)) begin : g_width_check
        $error("my_fir: OutputWidth too small for InputWidth and FIR_size");
    end

    fir_state_e                    state_q;
    logic [IDX_W-1:0]              idx_q;
    logic signed [InputWidth-1:0]  x_q [FIR_size];
    logic signed [OutputWidth-1:0] acc_q;
    logic signed [OutputWidth-1:0] out_q;
    logic                          valid_q;

    logic [IDX_W-1:0]              rom_addr;
    logic signed [InputWidth-1:0]  coef;
    logic signed [PROD_W-1:0]      prod;
    logic signed [OutputWidth-1:0] prod_ext;

    // The ROM read is registered, so it is addressed one tap ahead of the MAC;
    // during SHIFT it fetches c[0] for the first MAC cycle.
    assign rom_addr = (state_q == MAC) ? idx_q + IDX_W'(1) : idx_q;

    my_fir_coeff_rom #(
        .DEPTH  (FIR_size),
        .WIDTH  (InputWidth),
        .ADDR_W (IDX_W),
        .INIT   (COEFF_INIT)
    ) u_coeff_rom (
        .clk    (clk),
        .rst    (rst),
        .addr_i (rom_addr),
        .data_o (coef)
    );

    assign prod     = coef * x_q[idx_q];
    assign prod_ext = {{(OutputWidth-PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            for (int k = 0; k < FIR_size; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.inputValid) begin
                        x_q[0] <= bus.FIR_input;
                        for (int k = 1; k < FIR_size; k++) begin
                            x_q[k] <= x_q[k-1];
                        end
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q <= acc_q + prod_ext;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    out_q   <= acc_q;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.outputValid = valid_q;
    assign bus.FIR_output  = out_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_my_fir.sv
// Directed bench for my_fir: three filters with different coefficient sets share clock and reset.
module tb_my_fir;
    import my_fir_pkg::*;

    localparam int IW   = 16;
    localparam int OW   = 38;
    localparam int N    = 64;
    localparam int LAT  = N + 3;
    localparam int WAIT = 200;

    function automatic logic [N*IW-1:0] ramp_coeffs();
        logic [N*IW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            v[k*IW +: IW] = IW'(k + 1);
        end
        return v;
    endfunction

    localparam logic [N*IW-1:0] COEF_A = ramp_coeffs();
    localparam logic [N*IW-1:0] COEF_B = {N{16'h8000}};
    localparam logic [N*IW-1:0] COEF_C = {{(N-1)*IW{1'b0}}, 16'h7FFF};

    logic       clk;
    logic       rst;
    fir_state_e st_a, st_b, st_c;

    int n_checks = 0;
    int n_pass   = 0;

    my_fir_if #(.InputWidth(IW), .OutputWidth(OW)) if_a ();
    my_fir_if #(.InputWidth(IW), .OutputWidth(OW)) if_b ();
    my_fir_if #(.InputWidth(IW), .OutputWidth(OW)) if_c ();

    my_fir #(.InputWidth(IW), .OutputWidth(OW), .FIR_size(N), .COEFF_INIT(COEF_A))
        dut_a (.clk(clk), .rst(rst), .bus(if_a), .state_o(st_a));
    my_fir #(.InputWidth(IW), .OutputWidth(OW), .FIR_size(N), .COEFF_INIT(COEF_B))
        dut_b (.clk(clk), .rst(rst), .bus(if_b), .state_o(st_b));
    my_fir #(.InputWidth(IW), .OutputWidth(OW), .FIR_size(N), .COEFF_INIT(COEF_C))
        dut_c (.clk(clk), .rst(rst), .bus(if_c), .state_o(st_c));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic get_ov(input int sel);
        case (sel)
            0:       return if_a.outputValid;
            1:       return if_b.outputValid;
            default: return if_c.outputValid;
        endcase
    endfunction

    function automatic logic [OW-1:0] get_out(input int sel);
        case (sel)
            0:       return if_a.FIR_output;
            1:       return if_b.FIR_output;
            default: return if_c.FIR_output;
        endcase
    endfunction

    // driver: one-cycle inputValid strobe, returns at the negedge after the sampling edge
    task automatic pulse(input int sel, input logic [IW-1:0] x);
        @(negedge clk);
        case (sel)
            0:       begin if_a.inputValid = 1'b1; if_a.FIR_input = x; end
            1:       begin if_b.inputValid = 1'b1; if_b.FIR_input = x; end
            default: begin if_c.inputValid = 1'b1; if_c.FIR_input = x; end
        endcase
        @(negedge clk);
        if_a.inputValid = 1'b0;
        if_b.inputValid = 1'b0;
        if_c.inputValid = 1'b0;
    endtask

    task automatic wait_out(input int sel, output int lat, output logic [OW-1:0] y);
        lat = 1;
        while (!get_ov(sel) && lat < WAIT) begin
            @(negedge clk);
            lat++;
        end
        y = get_out(sel);
    endtask

    task automatic count_ov(input int sel, input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (get_ov(sel)) n++;
        end
    endtask

    task automatic send_sample(input int sel, input logic [IW-1:0] x, input string tag,
                               input logic [OW-1:0] exp_y);
        int          lat;
        logic [OW-1:0] y;
        pulse(sel, x);
        wait_out(sel, lat, y);
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check(tag, 64'(y), 64'(exp_y));
        @(negedge clk);
        check({tag, "_strobe_len"}, 64'(get_ov(sel)), 64'd0);
    endtask

    initial begin
        int            n;
        int            lat;
        logic [OW-1:0] y;

        if_a.inputValid = 1'b0; if_a.FIR_input = '0;
        if_b.inputValid = 1'b0; if_b.FIR_input = '0;
        if_c.inputValid = 1'b0; if_c.FIR_input = '0;
        rst = 1'b0;

        // reset state, during and after reset
        #2;
        check("rst_ov_a",  64'(if_a.outputValid), 64'd0);
        check("rst_out_a", 64'(if_a.FIR_output),  64'd0);
        check("rst_st_a",  64'(st_a),             64'(IDLE));
        #11;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ov_b",  64'(if_b.outputValid), 64'd0);
        check("post_rst_out_b", 64'(if_b.FIR_output),  64'd0);
        check("post_rst_out_c", 64'(if_c.FIR_output),  64'd0);

        // impulse response with c[k]=k+1
        send_sample(0, 16'd1, "impulse", 38'd1);
        for (int k = 1; k < N; k++) begin
            send_sample(0, 16'd0, "impulse", OW'(k + 1));
        end

        // full-scale negative inputs and coefficients: k-th output is k*2^30
        for (int k = 1; k <= N; k++) begin
            send_sample(1, 16'h8000, "full_scale", OW'(k) << 30);
        end
        check("full_scale_last", 64'(if_b.FIR_output), 64'h10_0000_0000);

        // mixed sign single tap
        send_sample(2, 16'h8000, "mixed_neg", 38'h3F_C000_8000);
        send_sample(2, 16'h7FFF, "mixed_pos", 38'h00_3FFF_0001);

        // busy drop: second strobe 10 cycles after the first must be ignored
        pulse(0, 16'd5);
        repeat (8) @(negedge clk);
        pulse(0, 16'd7);
        wait_out(0, lat, y);
        check("busy_first_out", 64'(y), 64'd5);
        count_ov(0, 80, n);
        check("busy_extra_strobes", 64'(n), 64'd0);
        send_sample(0, 16'd0, "busy_history", 38'd10);

        // abort: reset during MAC, no result, history cleared
        pulse(0, 16'd9);
        repeat (30) @(negedge clk);
        check("abort_in_mac", 64'(st_a), 64'(MAC));
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_cleared", 64'(if_a.FIR_output), 64'd0);
        check("abort_state_idle",  64'(st_a),            64'(IDLE));
        rst = 1'b1;
        count_ov(0, 80, n);
        check("abort_no_strobe", 64'(n), 64'd0);
        send_sample(0, 16'd2, "abort_fresh_history", 38'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
